fu_result_collector: RTL and testbench

Result-side counterpart of the tile's adder functional unit. Captures the four per-lane sums, carries and acks the FU produces, groups them according to the active lane configuration (4x16, 2x32, 1x64), and delivers one packed result entry per completed operation over a valid/ready interface through a small FIFO. Sits between the FU outputs and the tile's output crossbar, and back-pressures the FU's enable logic via `stall`.

---
 rtl/cgra_fu_pkg.sv | 50 +++++
 rtl/fu_result_fifo.sv | 62 ++++++
 rtl/fu_result_collector.sv | 169 ++++++++++++++++
 tb/tb_fu_result_collector.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_fu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cgra_fu_pkg
// Description : Shared types for the adder functional unit and its result
//               collector: lane modes, the result entry, collector FSM states
//               and small helpers for carry formatting and lane chaining.
// Revision    : 1.0 - initial release
// ============================================================================
package cgra_fu_pkg;

    localparam int FU_LANE_WIDTH = 16;
    localparam int FU_LANES      = 4;

    typedef enum logic [1:0] {
        MODE_4X16 = 2'd0,
        MODE_2X32 = 2'd1,
        MODE_1X64 = 2'd3
    } fu_mode_e;

    typedef struct packed {
        logic [FU_LANES*FU_LANE_WIDTH-1:0] data;
        logic [FU_LANES-1:0]               carry;
        logic [1:0]                        mode;
    } fu_result_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } collect_state_e;

    // Only the carry out of the top lane of each chain is meaningful.
    function automatic logic [3:0] fmt_carry(input logic [1:0] mode, input logic [3:0] c);
        case (mode)
            2'd1:    return {2'b00, c[3], c[1]};
            2'd3:    return {3'b000, c[3]};
            default: return c;
        endcase
    endfunction

    // Lanes whose ack must follow the ack of the lane just below them.
    function automatic logic [3:0] chain_mask(input logic [1:0] mode);
        case (mode)
            2'd1:    return 4'b1010;
            2'd3:    return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fu_result_fifo
// Description : Synchronous FIFO of fu_result_t entries with full/empty flags.
//               Storage is reset to zero so the head reads zero after reset.
//               Push is accepted on a full FIFO when a pop occurs that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fu_result_fifo
    import cgra_fu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  fu_result_t i_wr_entry,
    input  logic       i_pop,
    output fu_result_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0] c_FULL_CNT = (c_AW+1)'(DEPTH);

    fu_result_t      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wr_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fu_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : fu_result_collector
// Description : Gathers per-lane sums/carries/acks from the adder FU, groups
//               them by lane mode (4x16, 2x32, 1x64) and pushes one packed
//               result per completed operation into a small FIFO. Raises
//               stall while it cannot take a new operation and flags a sticky
//               cfg_err on protocol or configuration violations.
//               Optional: FU_COLLECT_STATS_EN adds a saturating stat_count of
//               pushed entries.
// Revision    : 1.0 - initial release
// ============================================================================
module fu_result_collector
    import cgra_fu_pkg::*;
#(
    parameter int WIDTH = FU_LANE_WIDTH,   // must match the package lane width
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         cfg,
    input  logic [4*WIDTH-1:0] lane_data,
    input  logic [3:0]         lane_carry,
    input  logic [3:0]         lane_ack,
    output logic [4*WIDTH-1:0] res_data,
    output logic [3:0]         res_carry,
    output logic [1:0]         res_mode,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               stall,
    output logic               cfg_err
`ifdef FU_COLLECT_STATS_EN
    ,
    output logic [15:0]        stat_count
`endif
);

    collect_state_e     r_state;
    collect_state_e     w_state_nxt;
    logic [1:0]         r_mode;
    logic [3:0]         r_got;
    logic [4*WIDTH-1:0] r_stage_data;
    logic [3:0]         r_stage_carry;
    logic               r_cfg_err;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    fu_result_t         w_head;
    fu_result_t         w_entry;
    logic               w_pop;
    logic               w_push;
    logic               w_stall;
    logic               w_accept;
    logic               w_err_set;
    logic [1:0]         w_mode_eff;
    logic [3:0]         w_new;
    logic [3:0]         w_got_eff;
    logic [4*WIDTH-1:0] w_stage_data_nxt;
    logic [3:0]         w_stage_carry_nxt;

    assign w_pop   = !w_fifo_empty && res_ready;
    // A fully collected but unpushed staging register also blocks new work.
    assign w_stall = w_fifo_full || (r_got == 4'hF);

    // Newly acked lanes overwrite staging; already-collected lanes keep data.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_stage_data_nxt[i*WIDTH +: WIDTH] =
            w_new[i] ? lane_data[i*WIDTH +: WIDTH] : r_stage_data[i*WIDTH +: WIDTH];
        assign w_stage_carry_nxt[i] = w_new[i] ? lane_carry[i] : r_stage_carry[i];
    end

    // Next state, ack acceptance, error detection and push decision.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_set   = 1'b0;
        w_mode_eff  = r_mode;
        case (r_state)
            ST_IDLE: begin
                w_mode_eff = cfg;
                if (|lane_ack) begin
                    if (w_stall || cfg == 2'd2) w_err_set = 1'b1;
                    else                        w_accept  = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (|lane_ack) begin
                    if (w_stall) w_err_set = 1'b1;
                    else         w_accept  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_new     = w_accept ? (lane_ack & ~r_got) : 4'b0000;
        w_got_eff = r_got | w_new;

        // An upper chained lane arriving before its lower neighbour.
        if (|(w_new & chain_mask(w_mode_eff) & ~{w_got_eff[2:0], 1'b1})) begin
            w_err_set = 1'b1;
        end

        w_push = (w_got_eff == 4'hF) && (!w_fifo_full || w_pop);

        if (w_push)               w_state_nxt = ST_IDLE;
        else if (w_got_eff != '0) w_state_nxt = ST_COLLECT;
    end

    assign w_entry.data  = w_stage_data_nxt;
    assign w_entry.carry = fmt_carry(w_mode_eff, w_stage_carry_nxt);
    assign w_entry.mode  = w_mode_eff;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Staging register, collected-lane mask, captured mode and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode        <= 2'd0;
            r_got         <= 4'b0000;
            r_stage_data  <= '0;
            r_stage_carry <= 4'b0000;
            r_cfg_err     <= 1'b0;
        end else begin
            r_stage_data  <= w_stage_data_nxt;
            r_stage_carry <= w_stage_carry_nxt;
            r_got         <= w_push ? 4'b0000 : w_got_eff;
            if (r_state == ST_IDLE && w_accept) r_mode <= cfg;
            r_cfg_err     <= r_cfg_err | w_err_set;
        end
    end

    fu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_wr_entry (w_entry),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign res_valid = !w_fifo_empty;
    assign res_data  = w_head.data;
    assign res_carry = w_head.carry;
    assign res_mode  = w_head.mode;
    assign stall     = w_stall;
    assign cfg_err   = r_cfg_err;

`ifdef FU_COLLECT_STATS_EN
    logic [15:0] r_stat_count;

    // Saturating count of pushed entries.
    always_ff @(posedge clk) begin
        if (reset)                                  r_stat_count <= 16'd0;
        else if (w_push && r_stat_count != 16'hFFFF) r_stat_count <= r_stat_count + 16'd1;
    end

    assign stat_count = r_stat_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fu_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fu_result_collector
// Description : Self-checking bench for fu_result_collector: directed vector
//               table, hand-written multi-cycle sequences and randomized
//               traffic against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_result_collector;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic               clk;
    logic               reset;
    logic [1:0]         cfg;
    logic [4*WIDTH-1:0] lane_data;
    logic [3:0]         lane_carry;
    logic [3:0]         lane_ack;
    logic [4*WIDTH-1:0] res_data;
    logic [3:0]         res_carry;
    logic [1:0]         res_mode;
    logic               res_valid;
    logic               res_ready;
    logic               stall;
    logic               cfg_err;
`ifdef FU_COLLECT_STATS_EN
    logic [15:0]        stat_count;
`endif

    fu_result_collector #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg        (cfg),
        .lane_data  (lane_data),
        .lane_carry (lane_carry),
        .lane_ack   (lane_ack),
        .res_data   (res_data),
        .res_carry  (res_carry),
        .res_mode   (res_mode),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .stall      (stall),
        .cfg_err    (cfg_err)
`ifdef FU_COLLECT_STATS_EN
        ,
        .stat_count (stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [63:0] d;
        logic [3:0]  c;
        logic [1:0]  m;
    } ent_t;

    ent_t        m_q[$];
    bit          m_busy;
    logic [1:0]  m_mode;
    logic [3:0]  m_got;
    logic [15:0] m_dat [4];
    logic [3:0]  m_car;
    bit          m_err;
    int          m_stat;

    function automatic bit lane_chained(input logic [1:0] mode, input int lane);
        if (mode == 2'd1) return (lane == 1 || lane == 3);
        if (mode == 2'd3) return (lane >= 1);
        return 1'b0;
    endfunction

    task automatic model_cycle(input logic [3:0] ack, input logic [63:0] d, input logic [3:0] c,
                               input logic [1:0] cf, input logic rdy, input logic rst);
        int sz;
        bit pop;
        bit blocked;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_busy = 0; m_mode = 0; m_got = 0; m_car = 0; m_err = 0; m_stat = 0;
            return;
        end
        sz      = m_q.size();
        pop     = (sz > 0) && rdy;
        blocked = (sz == DEPTH) || (m_got == 4'hF);
        if (ack != 0) begin
            if (blocked) m_err = 1;
            else if (!m_busy && cf == 2'd2) m_err = 1;
            else begin
                if (!m_busy) begin m_busy = 1; m_mode = cf; end
                for (int i = 0; i < 4; i++) begin
                    if (ack[i] && !m_got[i]) begin
                        if (lane_chained(m_mode, i) && !m_got[i-1]) m_err = 1;
                        m_dat[i] = d[16*i +: 16];
                        m_car[i] = c[i];
                        m_got[i] = 1'b1;
                    end
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (m_got == 4'hF && (sz < DEPTH || pop)) begin
            e.d = {m_dat[3], m_dat[2], m_dat[1], m_dat[0]};
            if (m_mode == 2'd1)      e.c = {2'b00, m_car[3], m_car[1]};
            else if (m_mode == 2'd3) e.c = {3'b000, m_car[3]};
            else                     e.c = m_car;
            e.m = m_mode;
            m_q.push_back(e);
            m_got = 0; m_busy = 0;
            if (m_stat < 16'hFFFF) m_stat++;
        end
    endtask

    // One clock: drive inputs, advance the model, compare just after the edge.
    task automatic step(input logic [3:0] ack, input logic [63:0] d, input logic [3:0] c,
                        input logic [1:0] cf, input logic rdy, input logic rst);
        lane_ack = ack; lane_data = d; lane_carry = c; cfg = cf; res_ready = rdy; reset = rst;
        model_cycle(ack, d, c, cf, rdy, rst);
        @(posedge clk);
        #1;
        check("res_valid", res_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("res_data", res_data, m_q[0].d);
            check("res_carry", res_carry, m_q[0].c);
            check("res_mode", res_mode, m_q[0].m);
        end
        if (rst) begin
            check("rst_data", res_data, 0);
            check("rst_carry", res_carry, 0);
            check("rst_mode", res_mode, 0);
        end
        check("stall", stall, (m_q.size() == DEPTH) || (m_got == 4'hF));
        check("cfg_err", cfg_err, m_err);
`ifdef FU_COLLECT_STATS_EN
        check("stat_count", stat_count, m_stat);
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [3:0]  ack;
        logic [63:0] data;
        logic [3:0]  carry;
        logic [1:0]  cfg;
        logic        rdy;
        logic        e_valid;
        logic [63:0] e_data;
        logic [3:0]  e_carry;
        logic [1:0]  e_mode;
        logic        e_stall;
        logic        e_err;
    } vec_t;

    localparam logic [63:0] D_M0 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] D_M3 = 64'hDDDD_CCCC_BBBB_AAAA;
    localparam logic [63:0] D_M1 = 64'h8888_7777_6666_5555;

    vec_t tbl [10];

    initial begin
        logic [15:0] v;
        logic [63:0] dk;

        tbl[0] = '{4'hF, D_M0, 4'hA, 2'd0, 1'b0, 1'b1, D_M0, 4'hA, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{4'h0, 64'h0, 4'h0, 2'd0, 1'b1, 1'b0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b0};
        tbl[2] = '{4'h1, D_M3, 4'h0, 2'd3, 1'b1, 1'b0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b0};
        tbl[3] = '{4'h2, D_M3, 4'h0, 2'd0, 1'b1, 1'b0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b0};
        tbl[4] = '{4'h4, D_M3, 4'h0, 2'd0, 1'b1, 1'b0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b0};
        tbl[5] = '{4'h8, D_M3, 4'h8, 2'd0, 1'b0, 1'b1, D_M3, 4'h1, 2'd3, 1'b0, 1'b0};
        tbl[6] = '{4'h0, 64'h0, 4'h0, 2'd0, 1'b1, 1'b0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b0};
        tbl[7] = '{4'h2, D_M1, 4'h0, 2'd1, 1'b1, 1'b0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b1};
        tbl[8] = '{4'hD, D_M1, 4'hA, 2'd1, 1'b0, 1'b1, D_M1, 4'h2, 2'd1, 1'b0, 1'b1};
        tbl[9] = '{4'h0, 64'h0, 4'h0, 2'd0, 1'b1, 1'b0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b1};

        lane_ack = 0; lane_data = 0; lane_carry = 0; cfg = 0; res_ready = 0; reset = 1;

        // Reset state.
        step(4'h0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b1);
        step(4'h0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b1);
        check("reset_valid", res_valid, 0);
        check("reset_stall", stall, 0);
        check("reset_err", cfg_err, 0);

        // Table: mode 0 single cycle, mode 3 staggered with cfg change, mode 1 order error.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].ack, tbl[i].data, tbl[i].carry, tbl[i].cfg, tbl[i].rdy, 1'b0);
            check($sformatf("tbl%0d_valid", i), res_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                check($sformatf("tbl%0d_data", i), res_data, tbl[i].e_data);
                check($sformatf("tbl%0d_carry", i), res_carry, tbl[i].e_carry);
                check($sformatf("tbl%0d_mode", i), res_mode, tbl[i].e_mode);
            end
            check($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
            check($sformatf("tbl%0d_err", i), cfg_err, tbl[i].e_err);
        end

        // Illegal cfg with an ack: error, no entry, FSM stays idle.
        step(4'h0, 64'h0, 4'h0, 2'd0, 1'b1, 1'b1);
        step(4'h3, D_M0, 4'h0, 2'd2, 1'b1, 1'b0);
        check("cfg2_err", cfg_err, 1);
        step(4'h0, 64'h0, 4'h0, 2'd0, 1'b1, 1'b0);
        check("cfg2_noentry", res_valid, 0);
        step(4'hF, D_M3, 4'h5, 2'd0, 1'b0, 1'b0);
        check("cfg2_then_op_valid", res_valid, 1);
        check("cfg2_then_op_data", res_data, D_M3);

        // Reset mid-collection with got = 0011 discards the partial operation.
        step(4'h0, 64'h0, 4'h0, 2'd0, 1'b1, 1'b1);
        step(4'h3, D_M1, 4'h3, 2'd0, 1'b1, 1'b0);
        step(4'h0, 64'h0, 4'h0, 2'd0, 1'b1, 1'b1);
        check("midrst_valid", res_valid, 0);
        check("midrst_data", res_data, 0);
        check("midrst_stall", stall, 0);
        check("midrst_err", cfg_err, 0);
        step(4'hF, D_M0, 4'h6, 2'd0, 1'b0, 1'b0);
        check("midrst_clean_data", res_data, D_M0);
        check("midrst_clean_carry", res_carry, 4'h6);
        check("midrst_clean_err", cfg_err, 0);

        // Fill the FIFO with the consumer stalled, ack during stall, then drain.
        step(4'h0, 64'h0, 4'h0, 2'd0, 1'b0, 1'b1);
        for (int k = 1; k <= DEPTH; k++) begin
            check($sformatf("fill%0d_stall_before", k), stall, 0);
            v  = 16'(k);
            dk = {v, v, v, v};
            step(4'hF, dk, 4'h0, 2'd0, 1'b0, 1'b0);
        end
        check("fill_stall", stall, 1);
        step(4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 2'd0, 1'b0, 1'b0);
        check("stall_ack_err", cfg_err, 1);
        check("stall_ack_still", stall, 1);
        for (int k = 1; k <= DEPTH; k++) begin
            v  = 16'(k);
            dk = {v, v, v, v};
            check($sformatf("drain%0d_data", k), res_data, dk);
            step(4'h0, 64'h0, 4'h0, 2'd0, 1'b1, 1'b0);
        end
        check("drained_valid", res_valid, 0);
        check("drained_stall", stall, 0);

`ifdef FU_COLLECT_STATS_EN
        step(4'h0, 64'h0, 4'h0, 2'd0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(4'hF, D_M3, 4'h0, 2'd0, 1'b1, 1'b0);
        check("stat_three", stat_count, 3);
`endif

        // Randomized traffic against the model.
        step(4'h0, 64'h0, 4'h0, 2'd0, 1'b1, 1'b1);
        for (int n = 0; n < 600; n++) begin
            logic [3:0]  r_ack;
            logic [1:0]  r_cfg;
            logic [63:0] r_d;
            r_ack = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            case ($urandom_range(0, 9))
                0:       r_cfg = 2'd2;
                1, 2, 3: r_cfg = 2'd1;
                4, 5, 6: r_cfg = 2'd3;
                default: r_cfg = 2'd0;
            endcase
            r_d = {$urandom, $urandom};
            step(r_ack, r_d, 4'($urandom_range(0, 15)), r_cfg,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 79) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
